motor_phase_deadtime_driver: RTL and testbench
==============================================

// Module: motor_phase_deadtime_driver
// PURPOSE
//  Per-phase half-bridge gate command generator for IRS2007S-class drivers, generalised to N phases.
//  Maps a 2-bit off/down/up command per phase to HIN (active-high) and nLIN (active-low).
//  Enforces programmable dead time on every switch-on.
//  Adds a latched fault shutdown, a global enable and illegal-command flagging.
//  Sits between the commutation/PWM logic and the gate-driver pins.
// PARAMETERS
//  PHASES  3  number of half-bridge phases
//  DT_W    8  width of dead-time setting and per-phase off counter
// PORTS
//  clk            in   1            system clock, all logic on rising edge
//  nRst           in   1            asynchronous active-low reset
//  enI            in   1            1 = drive allowed; 0 = all switches off (not latched)
//  faultI         in   1            synchronous over-current/fault input, active-high
//  faultClrI      in   1            single-cycle pulse that clears the latched fault
//  deadI          in   DT_W         dead time in clk cycles; 0 is treated as 1
//  down1_up2i     in   2*PHASES     per-phase command [2p+1:2p]: 0 off, 1 low-side on, 2 high-side on, 3 illegal
//  HinO           out  PHASES       high-side gate command, 1 = on
//  nLinO          out  PHASES       low-side gate command, 0 = on
//  faultO         out  1            latched fault status
//  illegalO       out  PHASES       1-cycle pulse per phase when cmd==3 is sampled
// BEHAVIOUR
//  Reset (nRst=0, async):
//   - HinO=0, nLinO=all 1, faultO=0, illegalO=0.
//   - Every phase in state OFF with offCnt=0.
//  Per-phase FSM, states OFF / HI / LO; outputs are registered decodes of the state.
//   - OFF: HinO=0, nLinO=1.  HI: HinO=1, nLinO=1.  LO: HinO=0, nLinO=0.
//  Dead time D = max(deadI,1), sampled each cycle.
//  offCnt: increments every cycle in OFF, saturating at 2^DT_W-1. Cleared to 0 on entering OFF.
//  go = enI & ~faultI & ~faultO.
//  OFF -> HI when cmd==2 & go & offCnt>=D-1.
//  OFF -> LO when cmd==1 & go & offCnt>=D-1.
//  HI -> OFF when cmd!=2 or ~go. LO -> OFF when cmd!=1 or ~go.
//  HI and LO are never adjacent: every change of side passes through OFF.
//  Result: after any switch-off at edge t, both switches stay off for exactly D cycles. The opposite side turns on at edge t+D at the earliest.
//  After reset release, the earliest switch-on is at the D-th rising edge.
//  Switch-off latency: 1 edge from sampling cmd change, enI=0 or faultI=1.
//  deadI changed during a dead interval: the new value applies from the next compare. The already-elapsed offCnt counts toward it.
//  cmd==3: treated as off (phase goes or stays OFF). illegalO[p]=1 for every cycle cmd==3 is sampled.
//  Fault latching:
//   - faultI=1 sampled -> faultO=1 at the same edge that forces all phases to OFF.
//   - faultO holds until a cycle with faultClrI=1 & faultI=0. faultO=0 at that edge.
//   - faultClrI while faultI=1 is ignored.
//   - Simultaneous faultI=1 and faultClrI=1: the fault wins.
//   - After clear, phases re-enter only via the normal OFF dead-time rule. offCnt has kept counting during the fault, so if D is already met, switch-on is immediate.
//  enI=0: all phases go OFF next edge. No latch; offCnt runs normally.
//  Phases are independent. Cross-phase simultaneity is allowed.
// TESTING
//  1. Reset, deadI=4, phase0 cmd=2 held from release -> HinO[0] rises on edge 4, nLinO stays 1.
//  2. Phase0 HI, cmd 2->1 at edge t, deadI=4 -> HinO[0]=0 at t. nLinO[0]=0 at t+4. Both off exactly 4 cycles. HinO&~nLinO never true.
//  3. deadI=0, toggle cmd 2/1 every cycle -> a 1-cycle off gap appears on each side change. No shoot-through.
//  4. Phase1 LO, faultI=1 one cycle -> nLinO[1]=1 next edge, faultO=1. faultClrI with faultI=1 is ignored. Clear with faultI=0 -> faultO=0, LO resumes next edge (offCnt>=D).
//  5. cmd=3 on phase2 for 3 cycles while HI -> HinO[2]=0 next edge. illegalO[2] high for 3 cycles.
//  6. PHASES=6, DT_W=4, deadI=15, independent random cmds, enI toggling -> scoreboard: per-phase off gap >=15 before every switch-on. All off while enI=0.

Source files
------------

// File: rtl/motor_phase_deadtime_driver.sv
// Per-phase half-bridge gate command generator with dead-time insertion,
// latched fault shutdown, global enable and illegal-command flagging.
//
// state  | meaning
// OFF    | both switches off; off_cnt counts cycles spent off
// LO     | low-side switch on (nLinO=0)
// HI     | high-side switch on (HinO=1)
module motor_phase_deadtime_driver #(
   parameter int PHASES = 3,
   parameter int DT_W   = 8
) (
   input  logic                  clk,
   input  logic                  nRst,
   input  logic                  enI,
   input  logic                  faultI,
   input  logic                  faultClrI,
   input  logic [DT_W-1:0]       deadI,
   input  logic [2*PHASES-1:0]   down1_up2i,
   output logic [PHASES-1:0]     HinO,
   output logic [PHASES-1:0]     nLinO,
   output logic                  faultO,
   output logic [PHASES-1:0]     illegalO
);

   // State codes equal the command codes they serve, so a command compares directly.
   localparam logic [1:0] ST_OFF = 2'd0;
   localparam logic [1:0] ST_LO  = 2'd1;
   localparam logic [1:0] ST_HI  = 2'd2;

   logic            go;
   logic [DT_W-1:0] dead_eff;
   logic [DT_W-1:0] dead_m1;
   logic [1:0]      cmd       [PHASES];
   logic [1:0]      state     [PHASES];
   logic [1:0]      state_nxt [PHASES];
   logic [DT_W-1:0] off_cnt   [PHASES];

   assign go       = enI & ~faultI & ~faultO;
   assign dead_eff = (deadI == '0) ? DT_W'(1) : deadI;
   assign dead_m1  = dead_eff - DT_W'(1);

   always_comb begin
      for (int p = 0; p < PHASES; p++) begin
         cmd[p]       = down1_up2i[2*p +: 2];
         state_nxt[p] = state[p];
         case (state[p])
            ST_OFF: begin
               if (go && (off_cnt[p] >= dead_m1) && (cmd[p] == ST_HI || cmd[p] == ST_LO))
                  state_nxt[p] = cmd[p];
            end
            ST_HI, ST_LO: begin
               // Any departure from the current side goes through OFF first.
               if (!go || (cmd[p] != state[p]))
                  state_nxt[p] = ST_OFF;
            end
            default: state_nxt[p] = ST_OFF;
         endcase
      end
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         faultO   <= 1'b0;
         HinO     <= '0;
         nLinO    <= '1;
         illegalO <= '0;
         for (int p = 0; p < PHASES; p++) begin
            state[p]   <= ST_OFF;
            off_cnt[p] <= '0;
         end
      end else begin
         faultO <= faultI | (faultO & ~faultClrI);
         for (int p = 0; p < PHASES; p++) begin
            state[p]    <= state_nxt[p];
            HinO[p]     <= (state_nxt[p] == ST_HI);
            nLinO[p]    <= (state_nxt[p] != ST_LO);
            illegalO[p] <= (cmd[p] == 2'd3);
            if ((state_nxt[p] != ST_OFF) || (state[p] != ST_OFF))
               off_cnt[p] <= '0;
            else if (off_cnt[p] != {DT_W{1'b1}})
               off_cnt[p] <= off_cnt[p] + DT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_motor_phase_deadtime_driver.sv
// Bench for motor_phase_deadtime_driver: directed table and sequences on a
// 3-phase instance, randomized model comparison on a 6-phase instance.
module tb_motor_phase_deadtime_driver;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // 3-phase, 8-bit dead-time instance
   logic       en_a = 1'b1, fault_a = 1'b0, clr_a = 1'b0;
   logic [7:0] dead_a = 8'd4;
   logic [5:0] cmd_a = '0;
   logic [2:0] hin_a, nlin_a, ill_a;
   logic       fault_o_a;

   // 6-phase, 4-bit dead-time instance
   logic        en_b = 1'b1, fault_b = 1'b0, clr_b = 1'b0;
   logic [3:0]  dead_b = 4'd15;
   logic [11:0] cmd_b = '0;
   logic [5:0]  hin_b, nlin_b, ill_b;
   logic        fault_o_b;

   motor_phase_deadtime_driver #(.PHASES(3), .DT_W(8)) dut_a (
      .clk(clk), .nRst(rst_n), .enI(en_a), .faultI(fault_a), .faultClrI(clr_a),
      .deadI(dead_a), .down1_up2i(cmd_a), .HinO(hin_a), .nLinO(nlin_a),
      .faultO(fault_o_a), .illegalO(ill_a));

   motor_phase_deadtime_driver #(.PHASES(6), .DT_W(4)) dut_b (
      .clk(clk), .nRst(rst_n), .enI(en_b), .faultI(fault_b), .faultClrI(clr_b),
      .deadI(dead_b), .down1_up2i(cmd_b), .HinO(hin_b), .nLinO(nlin_b),
      .faultO(fault_o_b), .illegalO(ill_b));

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      chk("shoot_a", 32'(hin_a & ~nlin_a), 32'd0);
   endtask

   // Reference model for the 6-phase instance: side 0 off, 1 low, 2 high;
   // gap = consecutive output samples (including the reset sample) spent off.
   int side_m [6];
   int gap_m  [6];
   bit fault_m;
   int obs_off [6];
   logic [5:0] prev_h, prev_l;

   task automatic model_reset();
      for (int p = 0; p < 6; p++) begin
         side_m[p] = 0; gap_m[p] = 1; obs_off[p] = 1;
      end
      fault_m = 1'b0; prev_h = '0; prev_l = '0;
   endtask

   task automatic model_step_and_check();
      int d, c, ns;
      bit go;
      logic [5:0] eh, enl, eil;
      logic on_now;
      d  = (dead_b == 0) ? 1 : int'(dead_b);
      go = en_b & ~fault_b & ~fault_m;
      for (int p = 0; p < 6; p++) begin
         c  = int'(cmd_b[2*p +: 2]);
         ns = side_m[p];
         if (side_m[p] != 0) begin
            if (!go || c != side_m[p]) ns = 0;
         end else if (go && (c == 1 || c == 2) && gap_m[p] >= d) begin
            ns = c;
         end
         if (ns == 0) gap_m[p] = (side_m[p] == 0) ? gap_m[p] + 1 : 1;
         side_m[p] = ns;
         eh[p]  = (ns == 2);
         enl[p] = (ns != 1);
         eil[p] = (c == 3);
      end
      fault_m = fault_b | (fault_m & ~clr_b);
      chk("hin_b", 32'(hin_b), 32'(eh));
      chk("nlin_b", 32'(nlin_b), 32'(enl));
      chk("ill_b", 32'(ill_b), 32'(eil));
      chk("fault_b", 32'(fault_o_b), 32'(fault_m));
      if (!en_b) chk("en_off_b", 32'({hin_b, ~nlin_b}), 32'd0);
      // Independent check on observed pins: off gap before every switch-on.
      for (int p = 0; p < 6; p++) begin
         on_now = hin_b[p] | ~nlin_b[p];
         if (on_now && !(prev_h[p] | prev_l[p]))
            chk("gap_b", 32'(obs_off[p] >= d), 32'd1);
         if ((hin_b[p] && prev_l[p]) || (~nlin_b[p] && prev_h[p]))
            chk("side_jump_b", 32'(p), 32'hFFFF);
         obs_off[p] = on_now ? 0 : obs_off[p] + 1;
      end
      prev_h = hin_b;
      prev_l = ~nlin_b;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst_hin_a", 32'(hin_a), 32'd0);
      chk("rst_nlin_a", 32'(nlin_a), 32'h7);
      chk("rst_fault_a", 32'(fault_o_a), 32'd0);
      chk("rst_ill_a", 32'(ill_a), 32'd0);
      chk("rst_nlin_b", 32'(nlin_b), 32'h3F);
      chk("rst_hin_b", 32'(hin_b), 32'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic [5:0] cmd;
      logic       en;
      logic [2:0] hin;
      logic [2:0] nlin;
      logic [2:0] ill;
   } vec_t;

   vec_t tbl [21];

   function automatic vec_t mk(logic [5:0] c, logic e, logic [2:0] h, logic [2:0] n, logic [2:0] i);
      vec_t v;
      v.cmd = c; v.en = e; v.hin = h; v.nlin = n; v.ill = i;
      return v;
   endfunction

   initial begin
      // Row r is sampled at rising edge r+1 after reset release; deadI=4 on phase 0.
      for (int r = 0; r < 3; r++)   tbl[r] = mk(6'h02, 1'b1, 3'b000, 3'b111, 3'b000);
      tbl[3] = mk(6'h02, 1'b1, 3'b001, 3'b111, 3'b000);
      for (int r = 4; r < 8; r++)   tbl[r] = mk(6'h01, 1'b1, 3'b000, 3'b111, 3'b000);
      for (int r = 8; r < 10; r++)  tbl[r] = mk(6'h01, 1'b1, 3'b000, 3'b110, 3'b000);
      for (int r = 10; r < 12; r++) tbl[r] = mk(6'h03, 1'b1, 3'b000, 3'b111, 3'b001);
      for (int r = 12; r < 14; r++) tbl[r] = mk(6'h00, 1'b1, 3'b000, 3'b111, 3'b000);
      tbl[14] = mk(6'h01, 1'b0, 3'b000, 3'b111, 3'b000);
      tbl[15] = mk(6'h01, 1'b1, 3'b000, 3'b110, 3'b000);
      tbl[16] = mk(6'h01, 1'b0, 3'b000, 3'b111, 3'b000);
      for (int r = 17; r < 20; r++) tbl[r] = mk(6'h01, 1'b1, 3'b000, 3'b111, 3'b000);
      tbl[20] = mk(6'h01, 1'b1, 3'b000, 3'b110, 3'b000);

      do_reset();
      for (int r = 0; r < 21; r++) begin
         cmd_a = tbl[r].cmd;
         en_a  = tbl[r].en;
         tick();
         chk($sformatf("tbl%0d_hin", r), 32'(hin_a), 32'(tbl[r].hin));
         chk($sformatf("tbl%0d_nlin", r), 32'(nlin_a), 32'(tbl[r].nlin));
         chk($sformatf("tbl%0d_ill", r), 32'(ill_a), 32'(tbl[r].ill));
         chk($sformatf("tbl%0d_fault", r), 32'(fault_o_a), 32'd0);
      end

      // Fault latch on phase 1 in LO.
      cmd_a = 6'b000100; en_a = 1'b1;
      tick();
      chk("flt_lo_on", 32'(nlin_a[1]), 32'd0);
      fault_a = 1'b1;
      tick();
      chk("flt_lo_off", 32'(nlin_a[1]), 32'd1);
      chk("flt_set", 32'(fault_o_a), 32'd1);
      clr_a = 1'b1;
      tick();
      chk("flt_clr_ignored", 32'(fault_o_a), 32'd1);
      fault_a = 1'b0; clr_a = 1'b0;
      tick();
      chk("flt_hold", 32'(fault_o_a), 32'd1);
      chk("flt_hold_off", 32'(nlin_a[1]), 32'd1);
      clr_a = 1'b1;
      tick();
      chk("flt_cleared", 32'(fault_o_a), 32'd0);
      chk("flt_clr_edge_off", 32'(nlin_a[1]), 32'd1);
      clr_a = 1'b0;
      tick();
      chk("flt_resume", 32'(nlin_a[1]), 32'd0);

      // Illegal command on phase 2 while HI.
      cmd_a = 6'b100000;
      tick();
      chk("ill_hi_on", 32'(hin_a[2]), 32'd1);
      cmd_a = 6'b110000;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("ill_hi_off", 32'(hin_a[2]), 32'd0);
         chk("ill_pulse", 32'(ill_a), 32'b100);
      end
      cmd_a = 6'b000000;
      tick();
      chk("ill_clear", 32'(ill_a), 32'd0);

      // deadI=0 behaves as 1: side changes every two cycles, one-cycle gaps.
      dead_a = 8'd0;
      cmd_a = 6'b000010;
      do_reset();
      for (int k = 1; k <= 12; k++) begin
         int c;
         bit eh, el;
         c = (((k - 1) / 2) % 2 == 0) ? 2 : 1;
         cmd_a = 6'(c);
         tick();
         eh = (k <= 2) || ((k % 2 == 0) && c == 2);
         el = (k > 2) && (k % 2 == 0) && c == 1;
         chk("d0_hin", 32'(hin_a[0]), 32'(eh));
         chk("d0_nlin", 32'(nlin_a[0]), 32'(!el));
      end

      // Randomized 6-phase run against the reference model.
      cmd_a = '0;
      dead_b = 4'd15; cmd_b = '0; en_b = 1'b1; fault_b = 1'b0; clr_b = 1'b0;
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         for (int p = 0; p < 6; p++)
            if ($urandom_range(19) == 0) cmd_b[2*p +: 2] = 2'($urandom_range(3));
         if ($urandom_range(39) == 0) en_b = ~en_b;
         fault_b = ($urandom_range(199) == 0);
         clr_b   = ($urandom_range(29) == 0);
         if (i >= 2000 && i % 100 == 0) dead_b = 4'($urandom_range(15));
         tick();
         model_step_and_check();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
